// File: rtl/elementwise_pkg.sv
// Shared types and constants for the element-wise multiplier scheduler.
// MTX_W and ew_result_t describe the default 8-bit lane configuration.
package elementwise_pkg;
    localparam int LANES  = 16;
    localparam int W_DFLT = 8;
    localparam int MTX_W  = LANES * W_DFLT;
    localparam int ID_W   = 1;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [MTX_W-1:0] mtx;
    } ew_result_t;
endpackage

// File: rtl/ew_result_fifo.sv
// Synchronous result FIFO with occupancy count; the head entry reads as zero
// while empty so the downstream bus is quiet between results.
module ew_result_fifo
    import elementwise_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ew_result_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    output T                       o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign w_push  = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = o_empty ? T'('0) : r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/elementwise_mul_sched.sv
// Two-requester round-robin scheduler feeding one pipelined element-wise
// multiplier; results are credit-buffered and returned tagged with requester id.
module elementwise_mul_sched
    import elementwise_pkg::*;
#(
    parameter int W          = 8,
    parameter int MUL_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [LANES*W-1:0] req0_u,
    input  logic [LANES*W-1:0] req0_v,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [LANES*W-1:0] req1_u,
    input  logic [LANES*W-1:0] req1_v,
    output logic [LANES*W-1:0] mul_u,
    output logic [LANES*W-1:0] mul_v,
    input  logic [LANES*W-1:0] mul_m,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_mtx,
    output logic               out_id,
    output logic               busy
);
    localparam int MW = LANES * W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TD = MUL_LAT + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [MW-1:0]   mtx;
    } res_t;

    logic          r_prio;
    logic [TD-1:0] r_tag_vld_p;
    logic [TD-1:0] r_tag_id_p;
    logic [MW-1:0] r_mul_u;
    logic [MW-1:0] r_mul_v;
    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_fifo_count;
    logic          w_credit_ok;
    logic          w_any_req;
    logic          w_grant;
    logic          w_accept;
    logic          w_fifo_empty;
    res_t          w_push_data;
    res_t          w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < TD; i++) w_inflight = w_inflight + CW'(r_tag_vld_p[i]);
    end

    // Every issued job already owns a FIFO slot, so the multiplier never stalls.
    assign w_credit_ok = ({1'b0, w_inflight} + {1'b0, w_fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign w_any_req   = req0_valid | req1_valid;
    assign w_grant     = (req0_valid & req1_valid) ? r_prio : req1_valid;
    assign req0_ready  = !rst & w_credit_ok & w_any_req & !w_grant;
    assign req1_ready  = !rst & w_credit_ok & w_any_req & w_grant;
    assign w_accept    = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio      <= 1'b0;
            r_tag_vld_p <= '0;
            r_mul_u     <= '0;
            r_mul_v     <= '0;
        end else begin
            r_tag_vld_p[0] <= w_accept;
            for (int i = 1; i < TD; i++) r_tag_vld_p[i] <= r_tag_vld_p[i-1];
            if (w_accept) begin
                r_prio  <= ~w_grant;
                r_mul_u <= w_grant ? req1_u : req0_u;
                r_mul_v <= w_grant ? req1_v : req0_v;
            end
        end
    end

    // Tag ids ride alongside the valids; only the valids need clearing.
    always_ff @(posedge clk) begin
        r_tag_id_p[0] <= w_grant;
        for (int i = 1; i < TD; i++) r_tag_id_p[i] <= r_tag_id_p[i-1];
    end

    assign w_push_data.id  = r_tag_id_p[TD-1];
    assign w_push_data.mtx = mul_m;

    ew_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (res_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_tag_vld_p[TD-1]),
        .i_data  (w_push_data),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign mul_u     = r_mul_u;
    assign mul_v     = r_mul_v;
    assign out_valid = !w_fifo_empty;
    assign out_mtx   = w_head.mtx;
    assign out_id    = w_head.id;
    assign busy      = (w_inflight != '0) | !w_fifo_empty;
endmodule

// File: tb/tb_elementwise_mul_sched.sv
// Self-checking bench: models the multiplier, keeps a spec-level scoreboard of
// accepted jobs and returned results, and runs one task per scenario.
module tb_elementwise_mul_sched;
    localparam int W          = 8;
    localparam int MUL_LAT    = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int MW         = 16 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [MW-1:0] req0_u, req0_v, req1_u, req1_v;
    logic [MW-1:0] mul_u, mul_v, mul_m, out_mtx;
    logic          out_valid, out_ready, out_id, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elementwise_mul_sched #(.W(W), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_u(req0_u), .req0_v(req0_v),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_u(req1_u), .req1_v(req1_v),
        .mul_u(mul_u), .mul_v(mul_v), .mul_m(mul_m),
        .out_valid(out_valid), .out_ready(out_ready), .out_mtx(out_mtx), .out_id(out_id),
        .busy(busy)
    );

    function automatic logic [MW-1:0] lanes_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        for (int k = 0; k < 16; k++) r[k*W +: W] = W'(int'(a[k*W +: W]) * int'(b[k*W +: W]));
        return r;
    endfunction

    function automatic logic [MW-1:0] splat(input int v);
        logic [MW-1:0] r;
        for (int k = 0; k < 16; k++) r[k*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [MW-1:0] pat1234(input bit squared);
        logic [MW-1:0] r;
        int v;
        for (int k = 0; k < 16; k++) begin
            v = (k % 4) + 1;
            r[k*W +: W] = squared ? W'(v * v) : W'(v);
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_mtx();
        logic [MW-1:0] r;
        for (int k = 0; k < 16; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    // Multiplier model: MUL_LAT register stages, reset by rstn = ~rst.
    logic [MW-1:0] mul_pipe [MUL_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
        end else begin
            mul_pipe[0] <= lanes_mul(mul_u, mul_v);
            for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end
    assign mul_m = mul_pipe[MUL_LAT-1];

    typedef struct packed {
        logic          id;
        logic [MW-1:0] mtx;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int   outst = 0;
    int   outst_max = 0;
    int   both_ready = 0;
    bit   mprio = 1'b0;

    // Handshake recorder: sampled mid-cycle, describes the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) begin
                exp_q.push_back('{1'b0, lanes_mul(req0_u, req0_v)});
                outst++;
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back('{1'b1, lanes_mul(req1_u, req1_v)});
                outst++;
            end
            if (req0_ready && req1_ready) both_ready++;
            if (out_valid && out_ready) begin
                obs_q.push_back('{out_id, out_mtx});
                outst--;
            end
            if (outst > outst_max) outst_max = outst;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        outst = 0;
        mprio = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
        clear_model();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        req0_u = pat1234(0); req0_v = pat1234(0); req1_u = splat(3); req1_v = splat(3);
        repeat (4) tick();
        @(negedge clk);
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b want 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %b want 0", req1_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_mtx !== '0) begin errors++; $display("FAIL reset_out_mtx got %h want 0", out_mtx); end
        checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL reset_out_id got %b want 0", out_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (mul_u !== '0 || mul_v !== '0) begin errors++; $display("FAIL reset_mul_uv got %h/%h want 0", mul_u, mul_v); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_single();
        apply_reset(4);
        out_ready = 1'b1;
        req0_u = pat1234(0); req0_v = pat1234(0); req0_valid = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        for (int j = 1; j <= MUL_LAT + 3; j++) begin
            @(negedge clk);
            if (j < MUL_LAT + 2) begin
                checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_pending[%0d] got valid=%b busy=%b want 0/1", j, out_valid, busy); end
            end else if (j == MUL_LAT + 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
                checks++; if (out_mtx !== pat1234(1)) begin errors++; $display("FAIL single_mtx got %h want %h", out_mtx, pat1234(1)); end
                checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL single_id got %b want 0", out_id); end
            end else begin
                checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_after_pop got busy=%b valid=%b want 0/0", busy, out_valid); end
            end
        end
        tick();
    endtask

    task automatic test_contention();
        bit ok;
        apply_reset(2);
        out_ready = 1'b1;
        req0_u = splat(2); req0_v = splat(2); req1_u = splat(3); req1_v = splat(3);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                errors++; $display("FAIL contention_grant[%0d] got r0=%b r1=%b want r0=%b", i, req0_ready, req1_ready, (i % 2 == 0));
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL contention_drain timeout got busy=%b want 0", busy); end
        checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL contention_count got %0d want 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 6; i++) begin
            checks++;
            if (obs_q[i].id !== (i % 2 == 1) || obs_q[i].mtx !== splat((i % 2 == 1) ? 9 : 4)) begin
                errors++; $display("FAIL contention_result[%0d] got id=%0d mtx=%h want id=%0d", i, obs_q[i].id, obs_q[i].mtx, i % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int acc;
        acc = 0;
        apply_reset(2);
        out_ready = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < FIFO_DEPTH + 4; i++) begin
            req0_u = rand_mtx(); req0_v = rand_mtx();
            @(negedge clk);
            if (req0_ready) acc++;
            if (i == FIFO_DEPTH + 1) begin
                checks++; if (out_mtx !== exp_q[0].mtx) begin errors++; $display("FAIL bp_head_early got %h want %h", out_mtx, exp_q[0].mtx); end
            end
            tick();
        end
        @(negedge clk);
        checks++; if (acc != FIFO_DEPTH) begin errors++; $display("FAIL bp_accepts got %0d want %0d", acc, FIFO_DEPTH); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b want 0", req0_ready); end
        checks++; if (out_valid !== 1'b1 || out_mtx !== exp_q[0].mtx) begin errors++; $display("FAIL bp_head_held got v=%b %h want %h", out_valid, out_mtx, exp_q[0].mtx); end
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_u = rand_mtx(); req0_v = rand_mtx();
            @(negedge clk);
            checks++; if (req0_ready !== (i >= 1)) begin errors++; $display("FAIL bp_resume[%0d] got %b want %b", i, req0_ready, (i >= 1)); end
            tick();
        end
        req0_valid = 1'b0;
        wait_idle(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain timeout got busy=%b want 0", busy); end
        checks++; if (obs_q.size() != exp_q.size() || exp_q.size() != FIFO_DEPTH + 7) begin
            errors++; $display("FAIL bp_count got %0d results want %0d (accepted %0d)", obs_q.size(), FIFO_DEPTH + 7, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_push_pop_wrap();
        bit ok;
        int cyc;
        int outs;
        bit credit, g, e0, e1;
        cyc = 0;
        apply_reset(2);
        while (exp_q.size() < 3 * FIFO_DEPTH + 4 && cyc < 400) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_u = rand_mtx(); req0_v = rand_mtx(); req1_u = rand_mtx(); req1_v = rand_mtx();
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            outs = exp_q.size() - obs_q.size();
            credit = (outs < FIFO_DEPTH);
            e0 = 1'b0; e1 = 1'b0; g = 1'b0;
            if (credit) begin
                if (req0_valid && req1_valid) g = mprio;
                else g = req1_valid;
                e0 = req0_valid && !g;
                e1 = req1_valid && g;
            end
            checks++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++; $display("FAIL wrap_ready[%0d] got r0=%b r1=%b want r0=%b r1=%b", cyc, req0_ready, req1_ready, e0, e1);
            end
            if (e0 || e1) mprio = ~g;
            tick();
            cyc++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        checks++; if (exp_q.size() < 3 * FIFO_DEPTH + 4) begin errors++; $display("FAIL wrap_progress got %0d accepts want %0d", exp_q.size(), 3 * FIFO_DEPTH + 4); end
        wait_idle(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_drain timeout got busy=%b want 0", busy); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(2);
        out_ready = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_u = rand_mtx(); req0_v = rand_mtx();
            tick();
        end
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_id !== 1'b0) begin errors++; $display("FAIL mid_reset_valid_id got %b/%b want 0/0", out_valid, out_id); end
        checks++; if (out_mtx !== '0) begin errors++; $display("FAIL mid_reset_mtx got %h want 0", out_mtx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        checks++; if (mul_u !== '0 || mul_v !== '0) begin errors++; $display("FAIL mid_reset_mul got %h/%h want 0", mul_u, mul_v); end
        tick();
        rst = 1'b0;
        clear_model();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_stale[%0d] got valid=%b busy=%b want 0/0", i, out_valid, busy); end
        end
        tick();
    endtask

    task automatic test_edge();
        bit ok;
        apply_reset(2);
        out_ready = 1'b1;
        req0_valid = 1'b1;
        req0_u = splat(255); req0_v = splat(255);
        tick();
        req0_u = splat(0); req0_v = rand_mtx();
        tick();
        req0_u = rand_mtx(); req0_v = splat(0);
        tick();
        req0_valid = 1'b0;
        wait_idle(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL edge_drain timeout got busy=%b want 0", busy); end
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL edge_count got %0d want 3", obs_q.size()); end
        if (obs_q.size() == 3) begin
            checks++; if (obs_q[0].mtx !== splat(1)) begin errors++; $display("FAIL edge_255x255 got %h want %h", obs_q[0].mtx, splat(1)); end
            checks++; if (obs_q[1].mtx !== '0 || obs_q[2].mtx !== '0) begin errors++; $display("FAIL edge_zero got %h %h want 0", obs_q[1].mtx, obs_q[2].mtx); end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL edge_result[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_no_overflow();
        checks++; if (outst_max != FIFO_DEPTH) begin errors++; $display("FAIL max_outstanding got %0d want %0d", outst_max, FIFO_DEPTH); end
        checks++; if (both_ready != 0) begin errors++; $display("FAIL dual_ready got %0d cycles want 0", both_ready); end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        req0_u = '0; req0_v = '0; req1_u = '0; req1_v = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_push_pop_wrap();
        test_reset_mid();
        test_edge();
        test_no_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/elementwise_mul_sched.md
# elementwise_mul_sched

Two-requester scheduler in front of one `elementwise_mul`, the pipelined element-wise multiplier for 4x4 matrices with W-bit lanes.
- Round-robin arbitration between the requesters.
- Issues operand pairs into the multiplier and tracks in-flight jobs through its fixed latency.
- Buffers results in a small FIFO, returned with the requester ID under valid/ready backpressure.
- Sits between the unified controller's operand fetch paths and the writeback stage.

## Interface
Parameters:
- `W`, 8, lane width; a matrix bus is 16*W bits.
- `MUL_LAT`, 1, multiplier latency: cycles from operands registered to `mul_m` valid.
- `FIFO_DEPTH`, 4, result buffer entries; power of two, at least 2.

Ports (`clk`, `rst`, `req*`, `mul_*`):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1 / `req0_ready` out 1: requester 0 handshake.
- `req0_u`, `req0_v` in 16*W: requester 0 operand matrices, lane k at bits [k*W+W-1:k*W].
- `req1_valid` in 1 / `req1_ready` out 1 / `req1_u`, `req1_v` in 16*W: requester 1, same format.
- `mul_u`, `mul_v` out 16*W: registered operands to `elementwise_mul`.
- `mul_m` in 16*W: multiplier result, treated as an opaque bus.

Ports (`out_*`, status):
- `out_valid` out 1 / `out_ready` in 1: result handshake.
- `out_mtx` out 16*W: result matrix.
- `out_id` out 1: requester that issued the job.
- `busy` out 1: high while any job is in flight or the FIFO is non-empty.

## Operation
- **Credit:** `credit_ok = (inflight + fifo_count) < FIFO_DEPTH`. `inflight` counts jobs in the MUL_LAT+1 stage tracker. A job is never issued without a guaranteed FIFO slot, so results are never dropped and the multiplier is never stalled.
- **Arbitration:** round-robin pointer `prio` (0 or 1).
  - Both requesters valid and `credit_ok`: grant `prio`.
  - One valid: grant it.
  - `reqN_ready = credit_ok & (grant == N)`. Ready is combinational from the valids and state, and is never asserted for a non-granted requester.
- **Pointer update:** after any accepted grant, `prio` becomes the other requester. With no accept, `prio` holds.
- **Issue:** on accept, `mul_u`/`mul_v` load the granted operands. A tag pipe of depth MUL_LAT+1 shifts {valid, id}. With no accept, `mul_u`/`mul_v` hold their previous value, and the tag valid is 0.
- **Capture:** when the tag pipe output is valid, `mul_m` and its id are pushed into the FIFO on that edge.
- **Result FIFO:**
  - `out_valid = !empty`; `out_mtx`/`out_id` are the head entry.
  - Pop on `out_valid & out_ready`.
  - A push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - With credits enforced, a full-FIFO push cannot occur. The bench asserts this.
- **Arithmetic:** none in this block. `inflight` and `fifo_count` are each clog2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - `req0_ready`, `req1_ready` = 0 during `rst`.
  - `mul_u`, `mul_v` = 0.
  - `out_valid` = 0, `out_mtx` = 0, `out_id` = 0, `busy` = 0.
  - Tag pipe cleared, FIFO empty, `prio` = 0.
- **Reset mid-operation:** all in-flight jobs and buffered results are discarded. No output handshake follows for them.
- **Latency:** accept at edge k → operands on `mul_u`/`mul_v` after k → FIFO push at edge k+1+MUL_LAT → `out_valid` high in the cycle after that edge. This is MUL_LAT+2 cycles to `out_valid` when the FIFO is empty and `out_ready` is high.
- **Throughput:** one accept per cycle sustained while `out_ready` = 1. Results return in issue order.
- **Backpressure:** with `out_ready` = 0, accepts stop once FIFO_DEPTH jobs are outstanding. Accepts resume the cycle after a pop frees a credit.
- **Held outputs:** `out_mtx`/`out_id` are stable while `out_valid & !out_ready`.

## Structure
- **Shared package** `elementwise_pkg`:
  - `LANES` = 16.
  - `MTX_W` = LANES*W.
  - `ID_W` = 1.
  - Typedef `ew_result_t` = {id, mtx}.
- **Sub-module** `ew_result_fifo`: synchronous FIFO (FIFO_DEPTH x `ew_result_t`) with count output.
- **Top module:** `elementwise_mul_sched` holds the arbiter, tag pipe and credit logic.
- **Parent wiring:** the parent instantiates `elementwise_mul` and ties its `rstn` to `~rst`.

## Test plan
- **Single job:** reset 4 cycles. req0 u = v = lanes {1,2,3,4} repeated, `out_ready` = 1. Expect `out_valid` after MUL_LAT+2 cycles, `out_mtx` lanes {1,4,9,16} repeated, `out_id` = 0, `busy` falls the cycle after the pop.
- **Contention:** both requesters valid continuously for 6 cycles, req0 lanes all 2, req1 lanes all 3. Expect grants alternating 0,1,0,1,…, outputs alternating lanes 4/9 with ids 0/1, and in order.
- **Backpressure:** hold `out_ready` = 0, req0 valid every cycle. Expect exactly FIFO_DEPTH accepts, then `req0_ready` = 0 and `out_mtx` stable. Release `out_ready`; expect one accept per cycle resuming, no loss or duplication.
- **Simultaneous push/pop at full-minus-one:** count is unchanged, ordering preserved, pointer wrap exercised over 3×FIFO_DEPTH jobs.
- **Reset mid-operation:** assert `rst` with 2 jobs in flight and 2 buffered. Next cycle all outputs are at reset values, and no stale result appears afterward.
- **Edge values:** lanes 255×255 and 0×x. `out_mtx` equals `mul_m` bit-exact, verified against a scoreboard.
